// File: rtl/reaction_timer_core.sv
// Reaction timer core: random foreperiod, lamp stimulus, BCD millisecond result.
// Optional best-score register enabled by defining RT_BEST_SCORE_EN.
module reaction_timer_core #(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned MIN_DELAY_MS = 1000,
   parameter int unsigned RAND_BITS    = 12,
   parameter int unsigned TIMEOUT_MS   = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   output logic                    led,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    done,
   output logic                    early,
   output logic                    timeout,
   output logic                    busy
`ifdef RT_BEST_SCORE_EN
   ,
   output logic [4*NUM_DIGITS-1:0] best_bcd
`endif
);

   localparam int unsigned BW  = 4 * NUM_DIGITS;
   localparam int unsigned DIV = CLK_HZ / 1000;
   localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned DW  = $clog2(MIN_DELAY_MS + 2 ** RAND_BITS + 1);

   // Binary to BCD, used only on constants at elaboration.
   function automatic logic [BW-1:0] to_bcd(input int unsigned v);
      logic [BW-1:0] r;
      int unsigned   t;
      r = '0;
      t = v;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   // Decimal increment with ripple carry across digits.
   function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   localparam logic [BW-1:0] TIMEOUT_BCD = to_bcd(TIMEOUT_MS);
   localparam logic [BW-1:0] ALL_NINES   = {NUM_DIGITS{4'h9}};

   if (DIV < 2) begin : g_bad_clk
      $error("CLK_HZ/1000 must be at least 2");
   end
   if (TIMEOUT_MS > 10 ** NUM_DIGITS - 1) begin : g_bad_timeout
      $error("TIMEOUT_MS does not fit in NUM_DIGITS BCD digits");
   end

   typedef enum logic [1:0] {StIdle, StWait, StTiming, StResult} state_e;

   state_e          r_state, w_state_next;
   logic            r_start, r_stop;
   logic [PW-1:0]   r_presc;
   logic [15:0]     r_lfsr;
   logic [DW-1:0]   r_delay;
   logic [BW-1:0]   r_bcd;
   logic            r_led, r_done, r_early, r_timeout;
   logic            w_start_edge, w_stop_edge, w_tick, w_enter_run;

   assign w_start_edge = start & ~r_start;
   assign w_stop_edge  = stop & ~r_stop;
   assign w_tick       = (r_presc == PW'(DIV - 1));
   assign w_enter_run  = (w_state_next != r_state) &&
                         ((w_state_next == StWait) || (w_state_next == StTiming));

   // Input history for edge detection, prescaler and LFSR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_start <= 1'b0;
         r_stop  <= 1'b0;
         r_presc <= '0;
         r_lfsr  <= 16'hACE1;
      end else begin
         r_start <= start;
         r_stop  <= stop;
         if (w_enter_run || w_tick) r_presc <= '0;
         else                       r_presc <= r_presc + PW'(1);
         // Right-shift Galois form of x^16+x^14+x^13+x^11+1; nonzero seed never reaches zero.
         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_next;
   end

   // Next-state logic; stop beats delay expiry and timeout.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle, StResult: if (w_start_edge) w_state_next = StWait;
         StWait: begin
            if (w_stop_edge)                              w_state_next = StResult;
            else if (w_tick && (r_delay <= DW'(1)))       w_state_next = StTiming;
         end
         StTiming: begin
            if (w_stop_edge)                              w_state_next = StResult;
            else if (w_tick && (r_bcd == TIMEOUT_BCD))    w_state_next = StResult;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Datapath: delay countdown, BCD count, lamp and result flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_delay   <= '0;
         r_bcd     <= '0;
         r_led     <= 1'b0;
         r_done    <= 1'b0;
         r_early   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle, StResult: begin
               if (w_start_edge) begin
                  r_delay   <= DW'(MIN_DELAY_MS) + DW'(r_lfsr[RAND_BITS-1:0]);
                  r_done    <= 1'b0;
                  r_early   <= 1'b0;
                  r_timeout <= 1'b0;
               end
            end
            StWait: begin
               if (w_stop_edge) begin
                  r_early <= 1'b1;
                  r_bcd   <= ALL_NINES;
               end else if (w_tick) begin
                  r_delay <= r_delay - DW'(1);
                  if (r_delay <= DW'(1)) begin
                     r_led <= 1'b1;
                     r_bcd <= '0;
                  end
               end
            end
            StTiming: begin
               if (w_stop_edge) begin
                  r_done <= 1'b1;
                  r_led  <= 1'b0;
               end else if (w_tick) begin
                  if (r_bcd == TIMEOUT_BCD) begin
                     r_timeout <= 1'b1;
                     r_led     <= 1'b0;
                  end else begin
                     r_bcd <= bcd_inc(r_bcd);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RT_BEST_SCORE_EN
   logic [BW-1:0] r_best;

   // Best valid score; only a timed response can improve it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_best <= ALL_NINES;
      end else if ((r_state == StTiming) && w_stop_edge && (r_bcd < r_best)) begin
         r_best <= r_bcd;
      end
   end

   assign best_bcd = r_best;
`endif

   // Outputs.
   always_comb begin
      busy    = (r_state == StWait) || (r_state == StTiming);
      led     = r_led;
      bcd     = r_bcd;
      done    = r_done;
      early   = r_early;
      timeout = r_timeout;
   end

endmodule
